// File: rtl/cam_orbit_ctrl.sv
// Per-frame camera orbit generator: Minsky sin/cos stepping plus shift-add radius scaling.
// Optional build macro CAM_ORBIT_RENORM_EN reloads (1.0, 0) whenever the angle index lands on 0.
module cam_orbit_ctrl #(
  parameter  int W           = 16,
  parameter  int FRAC        = 8,
  parameter  int SHIFT       = 6,
  parameter  int REV_STEPS   = 402,
  parameter  int RADIUS_W    = 8,
  parameter  int RADIUS_FRAC = 4,
  localparam int IDX_W       = $clog2(REV_STEPS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_sync,
  input  logic                enable,
  input  logic                dir,
  input  logic [1:0]          speed,
  input  logic [RADIUS_W-1:0] radius,
  output logic signed [W-1:0] cam_cos,
  output logic signed [W-1:0] cam_sin,
  output logic signed [W-1:0] cam_x,
  output logic signed [W-1:0] cam_z,
  output logic [IDX_W-1:0]    angle_idx,
  output logic                valid,
  output logic                busy,
  output logic                overrun
);

  localparam int AW = W + RADIUS_W;
  localparam int CW = $clog2(RADIUS_W + 1);
  localparam logic signed [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1} << FRAC;
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(REV_STEPS - 1);
  localparam logic [CW-1:0]       MUL_LAST = CW'(RADIUS_W - 1);

  typedef enum logic [1:0] {IDLE, ROTATE, MUL, DONE} state_t;

  state_t                state, state_d;
  logic [1:0]            step_cnt;
  logic                  dir_q;
  logic [RADIUS_W-1:0]   rad_q;
  logic [CW-1:0]         mul_cnt;
  logic signed [AW-1:0]  acc_x, acc_z, mc_x, mc_z;
  logic signed [W-1:0]   c_step, s_step, c_next, s_next;
  logic [IDX_W-1:0]      idx_next;
  logic                  start;

  assign start = frame_sync && enable;
  assign busy  = (state != IDLE);

  // One Minsky step; the sine update uses the freshly computed cosine so the orbit stays closed.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    c_step   = dir_q ? cam_cos + (cam_sin >>> SHIFT) : cam_cos - (cam_sin >>> SHIFT);
    s_step   = dir_q ? cam_sin - (c_step >>> SHIFT)  : cam_sin + (c_step >>> SHIFT);
    idx_next = dir_q ? ((angle_idx == '0) ? IDX_LAST : angle_idx - 1'b1)
                     : ((angle_idx == IDX_LAST) ? '0 : angle_idx + 1'b1);
    c_next   = c_step;
    s_next   = s_step;
`ifdef CAM_ORBIT_RENORM_EN
    if (idx_next == '0) begin
      c_next = ONE;
      s_next = '0;
    end
`else
`endif
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = ROTATE;
      ROTATE:  if (step_cnt == 2'd0) state_d = MUL;
      MUL:     if (mul_cnt == MUL_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignment so all registers update from pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cam_cos   <= ONE;
      cam_sin   <= '0;
      cam_x     <= '0;
      cam_z     <= '0;
      angle_idx <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      step_cnt  <= '0;
      dir_q     <= 1'b0;
      rad_q     <= '0;
      mul_cnt   <= '0;
      acc_x     <= '0;
      acc_z     <= '0;
      mc_x      <= '0;
      mc_z      <= '0;
    end else begin
      valid <= 1'b0;
      if (start && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (start) begin
          step_cnt <= speed;
          dir_q    <= dir;
          rad_q    <= radius;
        end
        ROTATE: begin
          cam_cos   <= c_next;
          cam_sin   <= s_next;
          angle_idx <= idx_next;
          step_cnt  <= step_cnt - 1'b1;
          if (step_cnt == 2'd0) begin
            // Multiplicands are taken from the final step's values, sign-extended.
            mc_x    <= {{RADIUS_W{c_next[W-1]}}, c_next};
            mc_z    <= {{RADIUS_W{s_next[W-1]}}, s_next};
            acc_x   <= '0;
            acc_z   <= '0;
            mul_cnt <= '0;
          end
        end
        MUL: begin
          if (rad_q[0]) begin
            acc_x <= acc_x + mc_x;
            acc_z <= acc_z + mc_z;
          end
          mc_x    <= mc_x <<< 1;
          mc_z    <= mc_z <<< 1;
          rad_q   <= rad_q >> 1;
          mul_cnt <= mul_cnt + 1'b1;
        end
        DONE: begin
          cam_x <= W'(acc_x >>> RADIUS_FRAC);
          cam_z <= W'(acc_z >>> RADIUS_FRAC);
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_orbit_ctrl.sv
// Self-checking bench for cam_orbit_ctrl: randomized frames against an integer-arithmetic orbit model.
// Honours CAM_ORBIT_RENORM_EN the same way the design does.
module tb_cam_orbit_ctrl;
  localparam int REV = 402;

  logic               clk = 1'b0;
  logic               rst, frame_sync, enable, dir;
  logic [1:0]         speed;
  logic [7:0]         radius;
  logic signed [15:0] cam_cos, cam_sin, cam_x, cam_z;
  logic [8:0]         angle_idx;
  logic               valid, busy, overrun;

  int total = 0;
  int bad   = 0;
  int m_c, m_s, m_idx, m_x, m_z;
  bit m_over;
  int valid_cnt;

  always #5 clk = ~clk;

  cam_orbit_ctrl dut (
    .clk(clk), .rst(rst), .frame_sync(frame_sync), .enable(enable), .dir(dir),
    .speed(speed), .radius(radius), .cam_cos(cam_cos), .cam_sin(cam_sin),
    .cam_x(cam_x), .cam_z(cam_z), .angle_idx(angle_idx), .valid(valid),
    .busy(busy), .overrun(overrun)
  );

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic logic [73:0] exp_vec();
    return {16'(m_c), 16'(m_s), 16'(m_x), 16'(m_z), 9'(m_idx), m_over};
  endfunction

  function automatic logic [73:0] obs_vec();
    return {cam_cos, cam_sin, cam_x, cam_z, angle_idx, overrun};
  endfunction

  task automatic model_reset();
    m_c = 256; m_s = 0; m_idx = 0; m_x = 0; m_z = 0; m_over = 1'b0;
  endtask

  // Orbit model: integer Minsky steps with 16-bit wrap, then product scaled by 2^-4 (floor).
  task automatic model_frame(input bit d, input int sp, input int r);
    for (int k = 0; k <= sp; k++) begin
      if (!d) begin
        m_c   = wrap16(m_c - (m_s >>> 6));
        m_s   = wrap16(m_s + (m_c >>> 6));
        m_idx = (m_idx + 1) % REV;
      end else begin
        m_c   = wrap16(m_c + (m_s >>> 6));
        m_s   = wrap16(m_s - (m_c >>> 6));
        m_idx = (m_idx + REV - 1) % REV;
      end
`ifdef CAM_ORBIT_RENORM_EN
      if (m_idx == 0) begin
        m_c = 256;
        m_s = 0;
      end
`else
`endif
    end
    m_x = wrap16((m_c * r) >>> 4);
    m_z = wrap16((m_s * r) >>> 4);
  endtask

  // Starts one frame, optionally scrambles inputs mid-flight, and checks latency, outputs and pulse width.
  task automatic run_frame(input bit d, input logic [1:0] sp, input logic [7:0] r, input bit perturb);
    int lat;
    @(negedge clk);
    dir = d; speed = sp; radius = r; enable = 1'b1; frame_sync = 1'b1;
    @(posedge clk); #1;
    frame_sync = 1'b0;
    if (perturb) begin
      dir = 1'($urandom); speed = 2'($urandom); radius = 8'($urandom); enable = 1'($urandom);
    end
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = n;
        break;
      end
    end
    if (lat > 0) valid_cnt++;
    model_frame(d, int'(sp), int'(r));
    total++;
    if (lat !== int'(sp) + 10) begin
      bad++;
      $display("FAIL frame_latency: got %0d edges, want %0d", lat, int'(sp) + 10);
    end
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL frame_outputs: got cos/sin/x/z/idx/ovr=%h, want %h", obs_vec(), exp_vec());
    end
    @(posedge clk); #1;
    total++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL valid_pulse: got valid=%b busy=%b after pulse, want 0 0", valid, busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; frame_sync = 1'b0; enable = 1'b0; dir = 1'b0; speed = '0; radius = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    total++;
    if (obs_vec() !== {16'h0100, 16'h0, 16'h0, 16'h0, 9'd0, 1'b0} || valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got %h valid=%b busy=%b, want cos=0100 rest 0", obs_vec(), valid, busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_ccw();
    run_frame(1'b0, 2'd0, 8'h50, 1'b0);
    total++;
    if ({cam_cos, cam_sin, cam_x, cam_z, angle_idx} !== {16'h0100, 16'h0004, 16'h0500, 16'h0014, 9'd1}) begin
      bad++;
      $display("FAIL single_ccw: got %h %h %h %h idx=%0d, want 0100 0004 0500 0014 idx=1",
               cam_cos, cam_sin, cam_x, cam_z, angle_idx);
    end
  endtask

  task automatic test_single_cw();
    run_frame(1'b1, 2'd0, 8'h50, 1'b0);
    total++;
    if ({cam_cos, cam_sin, cam_z, angle_idx} !== {16'h0100, 16'hFFFC, 16'hFFEC, 9'd401}) begin
      bad++;
      $display("FAIL single_cw: got cos=%h sin=%h z=%h idx=%0d, want 0100 FFFC FFEC 401",
               cam_cos, cam_sin, cam_z, angle_idx);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      run_frame(1'($urandom), 2'($urandom), 8'($urandom), 1'b1);
  endtask

  task automatic test_overrun();
    int vc;
    bit d;
    logic [1:0] sp;
    logic [7:0] r;
    d = 1'($urandom); sp = 2'($urandom); r = 8'($urandom);
    @(negedge clk);
    dir = d; speed = sp; radius = r; enable = 1'b1; frame_sync = 1'b1;
    @(posedge clk); #1;
    frame_sync = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    dir = ~d; speed = ~sp; radius = ~r; frame_sync = 1'b1;
    @(posedge clk); #1;
    frame_sync = 1'b0;
    vc = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (valid) vc++;
    end
    model_frame(d, int'(sp), int'(r));
    m_over = 1'b1;
    total++;
    if (vc !== 1) begin
      bad++;
      $display("FAIL overrun_valids: got %0d valid pulses, want 1", vc);
    end
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL overrun_outputs: got %h, want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_disabled();
    int vc;
    @(negedge clk);
    enable = 1'b0; frame_sync = 1'b1; dir = 1'($urandom); speed = 2'($urandom);
    @(posedge clk); #1;
    frame_sync = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL disabled_busy: got busy=%b, want 0", busy);
    end
    vc = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (valid) vc++;
    end
    total++;
    if (vc !== 0 || obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL disabled_frame: got %0d valids state %h, want 0 valids state %h", vc, obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid_mul();
    int vc;
    @(negedge clk);
    dir = 1'b0; speed = 2'd0; radius = 8'h50; enable = 1'b1; frame_sync = 1'b1;
    @(posedge clk); #1;
    frame_sync = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    total++;
    if (busy !== 1'b0 || cam_cos !== 16'h0100 || angle_idx !== 9'd0 || valid !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_mul: got busy=%b cos=%h idx=%0d valid=%b ovr=%b, want 0 0100 0 0 0",
               busy, cam_cos, angle_idx, valid, overrun);
    end
    @(negedge clk);
    rst = 1'b0;
    vc = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (valid) vc++;
    end
    total++;
    if (vc !== 0) begin
      bad++;
      $display("FAIL reset_no_valid: got %0d valids after reset, want 0", vc);
    end
  endtask

  task automatic test_full_rev();
    test_reset();
    valid_cnt = 0;
    for (int i = 0; i < 100; i++)
      run_frame(1'b0, 2'd3, 8'($urandom), 1'b0);
    run_frame(1'b0, 2'd1, 8'h50, 1'b0);
    total++;
    if (valid_cnt !== 101 || angle_idx !== 9'd0) begin
      bad++;
      $display("FAIL full_rev: got valids=%0d idx=%0d, want 101 and 0", valid_cnt, angle_idx);
    end
`ifdef CAM_ORBIT_RENORM_EN
    total++;
    if (cam_cos !== 16'h0100 || cam_sin !== 16'h0000) begin
      bad++;
      $display("FAIL full_rev_renorm: got cos=%h sin=%h, want 0100 0000", cam_cos, cam_sin);
    end
`else
`endif
  endtask

  initial begin
    rst = 1'b1; frame_sync = 1'b0; enable = 1'b0; dir = 1'b0; speed = '0; radius = '0;
    valid_cnt = 0;
    test_reset();
    test_single_ccw();
    test_reset();
    test_single_cw();
    test_random();
    test_overrun();
    test_disabled();
    test_reset_mid_mul();
    test_random();
    test_full_rev();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
